// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared types and constants for the SPI ADC front end.
//   state_e      - frame sequencer states
//   DEF_*        - default parameter values
//   cnt_width()  - counter width helper (clog2 with a floor of 1)
package adc_spi_pkg;

    localparam int unsigned DEF_CLK_DIV    = 8;
    localparam int unsigned DEF_FRAME_BITS = 16;
    localparam int unsigned DEF_LEAD_BITS  = 3;
    localparam int unsigned DEF_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Width of a counter that must hold values 0..n-1
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_spi_tick.sv
// adc_spi_tick: SCLK half-period tick generator.
//   clk, rst_n - clock, synchronous active-low reset
//   en         - count enable; while low the count is held at zero
//   tick_c     - one-cycle pulse on every CLK_DIV-th enabled cycle
module adc_spi_tick
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CW = cnt_width(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count 0..CLK_DIV-1 while enabled, restart from zero on each enable
    always_comb begin
        cnt_d  = cnt_q;
        tick_c = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(CLK_DIV - 1)) begin
            tick_c = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/adc_spi.sv
// adc_spi: chip-select framed serial read from an 8-bit SPI ADC.
//   clk, rst_n - clock, synchronous active-low reset
//   sample     - one-cycle conversion request (ignored while busy)
//   data_in    - ADC serial data (MISO), changes on SCLK falling edges
//   DATA_OUT   - last completed conversion, held until the next one
//   dv         - one-cycle pulse when DATA_OUT updates
//   busy       - frame in progress
//   CS         - ADC chip select, active-low
//   SCLK       - ADC serial clock, idle low
module adc_spi
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
    parameter int unsigned LEAD_BITS  = DEF_LEAD_BITS,
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 dv,
    output logic                 busy,
    output logic                 CS,
    output logic                 SCLK
);

    localparam int unsigned CW = cnt_width(2 * FRAME_BITS);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SETUP = SETUP;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_HOLD  = HOLD;

    logic [1:0]           state_q,    state_d;
    logic [CW-1:0]        half_q,     half_d;
    logic [CW-1:0]        bit_q,      bit_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 dv_q,       dv_d;
    logic                 busy_q,     busy_d;
    logic                 cs_q,       cs_d;
    logic                 sclk_q,     sclk_d;
    logic                 capture_c;
    logic                 in_window_c;
    logic                 tick_c;

    adc_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q != ST_IDLE),
        .tick_c (tick_c)
    );

    // Wrapping subtraction puts k < LEAD_BITS far above DATA_BITS
    assign in_window_c = (bit_q - CW'(LEAD_BITS)) < CW'(DATA_BITS);

    // Frame sequencer, SCLK generation and capture
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        dv_d       = 1'b0;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        capture_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                if (sample) begin
                    state_d = ST_SETUP;
                    cs_d    = 1'b0;
                    half_d  = '0;
                    bit_d   = '0;
                    shreg_d = '0;
                end
            end
            ST_SETUP: begin
                if (tick_c) begin
                    state_d   = ST_SHIFT;
                    sclk_d    = 1'b1;
                    capture_c = 1'b1;
                end
            end
            ST_SHIFT: begin
                // The rise on SHIFT entry is the first of 2*FRAME_BITS
                // half-periods; the tick after the last one ends the shift.
                if (tick_c) begin
                    if (half_q == CW'(2 * FRAME_BITS - 1)) begin
                        state_d = ST_HOLD;
                        sclk_d  = 1'b0;
                    end else begin
                        sclk_d    = ~sclk_q;
                        half_d    = half_q + CW'(1);
                        capture_c = ~sclk_q;
                    end
                end
            end
            ST_HOLD: begin
                if (tick_c) begin
                    state_d    = ST_IDLE;
                    cs_d       = 1'b1;
                    data_out_d = shreg_q;
                    dv_d       = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase

        // Sample data_in at every edge that drives SCLK high
        if (capture_c) begin
            bit_d = bit_q + CW'(1);
            if (in_window_c) begin
                shreg_d = (shreg_q << 1) | DATA_BITS'(data_in);
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            half_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            data_out_q <= '0;
            dv_q       <= 1'b0;
            busy_q     <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            dv_q       <= dv_d;
            busy_q     <= busy_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
        end
    end

    assign DATA_OUT = data_out_q;
    assign dv       = dv_q;
    assign busy     = busy_q;
    assign CS       = cs_q;
    assign SCLK     = sclk_q;

endmodule

// File: tb/tb_adc_spi.sv
// tb_adc_spi: self-checking bench for adc_spi.
// Instance a uses default parameters; instance b uses CLK_DIV=1,
// FRAME_BITS=8, LEAD_BITS=0, DATA_BITS=8. Each instance talks to a small
// behavioural ADC that shifts a frame out MSB first, updating on SCLK falls.
module tb_adc_spi;

    localparam int T_A = (2 * 16 + 2) * 8;   // 272
    localparam int T_B = (2 * 8 + 2) * 1;    // 18

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n;
    logic       sample_a, din_a, dv_a, busy_a, cs_a, sclk_a;
    logic [7:0] dout_a;
    logic       sample_b, din_b, dv_b, busy_b, cs_b, sclk_b;
    logic [7:0] dout_b;

    adc_spi u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample   (sample_a),
        .data_in  (din_a),
        .DATA_OUT (dout_a),
        .dv       (dv_a),
        .busy     (busy_a),
        .CS       (cs_a),
        .SCLK     (sclk_a)
    );

    adc_spi #(
        .CLK_DIV    (1),
        .FRAME_BITS (8),
        .LEAD_BITS  (0),
        .DATA_BITS  (8)
    ) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample   (sample_b),
        .data_in  (din_b),
        .DATA_OUT (dout_b),
        .dv       (dv_b),
        .busy     (busy_b),
        .CS       (cs_b),
        .SCLK     (sclk_b)
    );

    // Behavioural ADCs: first bit valid when CS falls, next bit on each SCLK fall
    logic [15:0] frame_a = '0;
    logic [7:0]  frame_b = '0;
    int          idx_a = 0;
    int          idx_b = 0;
    initial begin din_a = 1'b0; din_b = 1'b0; end

    always @(negedge cs_a) begin idx_a = 0; din_a = frame_a[15]; end
    always @(negedge sclk_a) if (!cs_a) begin
        idx_a++;
        din_a = (idx_a < 16) ? frame_a[15 - idx_a] : 1'b0;
    end
    always @(negedge cs_b) begin idx_b = 0; din_b = frame_b[7]; end
    always @(negedge sclk_b) if (!cs_b) begin
        idx_b++;
        din_b = (idx_b < 8) ? frame_b[7 - idx_b] : 1'b0;
    end

    // Pin monitor, sampled on the falling clock edge; counters are cumulative
    int   rises_a = 0, hi_bad_a = 0, cs_low_a = 0, dv_cnt_a = 0, dv_cnt_b = 0;
    int   hi_len = 0;
    logic sclk_prev = 1'b0;
    always @(negedge clk) begin
        if (sclk_a) hi_len++;
        else begin
            if (sclk_prev && hi_len != 8) hi_bad_a++;
            hi_len = 0;
        end
        if (sclk_a && !sclk_prev) rises_a++;
        if (!cs_a) cs_low_a++;
        if (dv_a)  dv_cnt_a++;
        if (dv_b)  dv_cnt_b++;
        sclk_prev = sclk_a;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the DATA_BITS=8 bits following the lead bits, MSB first
    function automatic logic [7:0] ref_word(input logic [15:0] frame, input int fbits, input int lead);
        return 8'(frame >> (fbits - lead - 8));
    endfunction

    // One complete read; lat is edges from the accepting edge to dv (-1 on timeout)
    task automatic do_read(input bit use_b, input logic [15:0] frame,
                           output int lat, output logic [7:0] got);
        int e0;
        lat = -1;
        if (use_b) frame_b = frame[7:0]; else frame_a = frame;
        @(posedge clk); #1;
        if (use_b) sample_b = 1'b1; else sample_a = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        sample_a = 1'b0;
        sample_b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ((use_b ? dv_b : dv_a) === 1'b1) begin
                lat = cyc - e0;
                break;
            end
            @(posedge clk); #1;
        end
        got = use_b ? dout_b : dout_a;
        @(negedge clk); #1;
    endtask

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  exp;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        int          lat, r0, h0, c0, d0, e0, e1;
        logic [7:0]  got;
        logic [15:0] fr;
        bit          seen;

        vecs[0] = '{16'b000_10100101_11011, 8'hA5};
        vecs[1] = '{16'b111_00111100_10101, 8'h3C};
        vecs[2] = '{16'b010_11111111_00000, 8'hFF};
        vecs[3] = '{16'b101_00000000_11111, 8'h00};
        vecs[4] = '{16'b000_01011010_01010, 8'h5A};

        rst_n    = 1'b0;
        sample_a = 1'b0;
        sample_b = 1'b0;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("reset_cs",   32'(cs_a),   32'h1);
        check("reset_sclk", 32'(sclk_a), 32'h0);
        check("reset_dout", 32'(dout_a), 32'h0);
        check("reset_dv",   32'(dv_a),   32'h0);
        check("reset_busy", 32'(busy_a), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed frames at default parameters
        for (int v = 0; v < 5; v++) begin
            r0 = rises_a; h0 = hi_bad_a; c0 = cs_low_a; d0 = dv_cnt_a;
            do_read(1'b0, vecs[v].frame, lat, got);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'(T_A));
            check($sformatf("vec%0d_data", v),    32'(got), 32'(vecs[v].exp));
            check($sformatf("vec%0d_rises", v),   32'(rises_a - r0), 32'd16);
            check($sformatf("vec%0d_hi_phase", v), 32'(hi_bad_a - h0), 32'd0);
            check($sformatf("vec%0d_cs_low", v),  32'(cs_low_a - c0), 32'(T_A));
            check($sformatf("vec%0d_dv_count", v), 32'(dv_cnt_a - d0), 32'd1);
        end

        // Random frames against the reference model
        for (int n = 0; n < 12; n++) begin
            fr = 16'($urandom);
            do_read(1'b0, fr, lat, got);
            check($sformatf("rand%0d_latency", n), 32'(lat), 32'(T_A));
            check($sformatf("rand%0d_data", n),    32'(got), 32'(ref_word(fr, 16, 3)));
        end

        // Second request mid-frame is ignored
        d0 = dv_cnt_a; c0 = cs_low_a;
        frame_a = 16'b110_11000011_00110;
        @(posedge clk); #1; sample_a = 1'b1;
        @(posedge clk); #1; sample_a = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check("busy_during_frame", 32'(busy_a), 32'h1);
        sample_a = 1'b1;
        @(posedge clk); #1; sample_a = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        check("busy_ignore_dv_count", 32'(dv_cnt_a - d0), 32'd1);
        check("busy_ignore_cs_low",   32'(cs_low_a - c0), 32'(T_A));
        check("busy_ignore_data",     32'(dout_a), 32'hC3);

        // Back-to-back: request in the dv cycle; frames start T+1 edges apart
        do_read(1'b0, 16'b000_00111100_00000, lat, got);
        check("b2b_first_data", 32'(got), 32'h3C);
        frame_a = 16'b000_11111111_00000;
        // re-run the first frame manually so the second sample lands in its dv cycle
        @(posedge clk); #1;
        frame_a = 16'b001_00111100_10000;
        sample_a = 1'b1;
        @(posedge clk); #1; sample_a = 1'b0;
        e0 = -1; seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (dv_a) begin
                seen = 1'b1;
                e0 = cyc;
                check("b2b_dv1_data", 32'(dout_a), 32'h3C);
                frame_a = 16'b000_11111111_00000;
                sample_a = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1; sample_a = 1'b0;
        check("b2b_accepted", 32'(busy_a), 32'h1);
        repeat (100) @(posedge clk);
        #1;
        check("b2b_hold_dout", 32'(dout_a), 32'h3C);
        e1 = -1; seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (dv_a) begin seen = 1'b1; e1 = cyc; end
            else begin @(posedge clk); #1; end
        end
        check("b2b_dv_spacing", 32'(e1 - e0), 32'(T_A + 1));
        check("b2b_dv2_data",   32'(dout_a), 32'hFF);

        // Reset mid-frame at the 7th SCLK rise
        frame_a = 16'hFFFF;
        r0 = rises_a;
        @(posedge clk); #1; sample_a = 1'b1;
        @(posedge clk); #1; sample_a = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (rises_a - r0 >= 7) break;
        end
        check("abort_reached_edge7", 32'(rises_a - r0), 32'd7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_cs",   32'(cs_a),   32'h1);
        check("abort_sclk", 32'(sclk_a), 32'h0);
        check("abort_busy", 32'(busy_a), 32'h0);
        check("abort_dout", 32'(dout_a), 32'h0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        d0 = dv_cnt_a;
        repeat (300) @(posedge clk);
        #1;
        check("abort_no_dv", 32'(dv_cnt_a - d0), 32'd0);
        do_read(1'b0, 16'b000_01011010_00000, lat, got);
        check("after_abort_latency", 32'(lat), 32'(T_A));
        check("after_abort_data",    32'(got), 32'h5A);

        // Minimal parameter set
        do_read(1'b1, 16'h0081, lat, got);
        check("sweep_latency", 32'(lat), 32'(T_B));
        check("sweep_data",    32'(got), 32'h81);
        for (int n = 0; n < 6; n++) begin
            fr = 16'($urandom_range(0, 255));
            do_read(1'b1, fr, lat, got);
            check($sformatf("sweep_rand%0d_latency", n), 32'(lat), 32'(T_B));
            check($sformatf("sweep_rand%0d_data", n),    32'(got), 32'(ref_word(fr, 8, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
